// File: rtl/dmux4way16_stream_pkg.sv
// Shared definitions for the 4-way 16-bit stream demultiplexer: channel indices,
// delivered-counter width and the select decoder.
package dmux4way16_stream_pkg;

  localparam int unsigned NumCh    = 4;
  localparam int unsigned CntWidth = 16;

  localparam logic [1:0] CH_A = 2'd0;
  localparam logic [1:0] CH_B = 2'd1;
  localparam logic [1:0] CH_C = 2'd2;
  localparam logic [1:0] CH_D = 2'd3;

  function automatic logic [NumCh-1:0] sel_to_onehot(input logic [1:0] sel);
    logic [NumCh-1:0] oh;
    oh = '0;
    unique case (sel)
      CH_A: oh[0] = 1'b1;
      CH_B: oh[1] = 1'b1;
      CH_C: oh[2] = 1'b1;
      CH_D: oh[3] = 1'b1;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/dmux_chan_fifo.sv
// One output channel: Depth-entry FIFO with a registered head word, valid/full flags
// and a wrapping delivered-word counter.
module dmux_chan_fifo
  import dmux4way16_stream_pkg::*;
#(
  parameter int unsigned Width = 16,
  parameter int unsigned Depth = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                push_i,
  input  logic [Width-1:0]    data_i,
  input  logic                ready_i,
  input  logic                cnt_clr_i,
  output logic                full_o,
  output logic                valid_o,
  output logic [Width-1:0]    data_o,
  output logic [CntWidth-1:0] cnt_o
);

  localparam int unsigned PtrW   = $clog2(Depth);
  localparam int unsigned CountW = PtrW + 1;
  localparam logic [CountW-1:0] DepthC = CountW'(Depth);
  localparam logic [CountW-1:0] OneC   = CountW'(1);

  logic [Width-1:0]    mem_q [Depth];
  logic [PtrW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [Width-1:0]    out_q, out_d;
  logic                valid_q;
  logic [CntWidth-1:0] cnt_q, cnt_d;
  logic                pop;

  assign pop    = valid_q & ready_i;
  assign full_o = (count_q == DepthC);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    out_d    = out_q;
    cnt_d    = cnt_q;

    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)    rd_ptr_d = rd_ptr_q + 1'b1;

    unique case ({push_i, pop})
      2'b10:   count_d = count_q + OneC;
      2'b01:   count_d = count_q - OneC;
      default: count_d = count_q;
    endcase

    // Head register: next stored entry, else the incoming word, else hold last value.
    if (pop) begin
      if (count_q > OneC) begin
        out_d = mem_q[rd_ptr_d];
      end else if (push_i) begin
        out_d = data_i;
      end
    end else if ((count_q == '0) && push_i) begin
      out_d = data_i;
    end

    if (cnt_clr_i) begin
      cnt_d = '0;
    end else if (pop) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < int'(Depth); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      out_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      if (push_i) mem_q[wr_ptr_q] <= data_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      out_q    <= out_d;
      valid_q  <= (count_d != '0);
      cnt_q    <= cnt_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = out_q;
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/dmux4way16_stream.sv
// 4-way stream demultiplexer: decodes IN_SEL, gates acceptance on the selected
// channel's full flag and fans the push out to four channel FIFOs.
module dmux4way16_stream
  import dmux4way16_stream_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 2
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic [WIDTH-1:0]    IN_DATA,
  input  logic [1:0]          IN_SEL,
  input  logic                IN_VALID,
  output logic                IN_READY,
  output logic [WIDTH-1:0]    OUT_A,
  output logic [WIDTH-1:0]    OUT_B,
  output logic [WIDTH-1:0]    OUT_C,
  output logic [WIDTH-1:0]    OUT_D,
  output logic                VALID_A,
  output logic                VALID_B,
  output logic                VALID_C,
  output logic                VALID_D,
  input  logic                READY_A,
  input  logic                READY_B,
  input  logic                READY_C,
  input  logic                READY_D,
  output logic [CntWidth-1:0] CNT_A,
  output logic [CntWidth-1:0] CNT_B,
  output logic [CntWidth-1:0] CNT_C,
  output logic [CntWidth-1:0] CNT_D,
  input  logic                CNT_CLR
);

  logic [NumCh-1:0]    sel_oh;
  logic [NumCh-1:0]    full;
  logic [NumCh-1:0]    push_en;
  logic [NumCh-1:0]    valid_v;
  logic [NumCh-1:0]    ready_v;
  logic [WIDTH-1:0]    out_v [NumCh];
  logic [CntWidth-1:0] cnt_v [NumCh];

  assign sel_oh  = sel_to_onehot(IN_SEL);
  // Depends only on IN_SEL and registered counts, never on a consumer READY.
  assign IN_READY = RESET_N & ~full[IN_SEL];
  assign push_en  = sel_oh & {NumCh{IN_VALID & IN_READY}};
  assign ready_v  = {READY_D, READY_C, READY_B, READY_A};

  for (genvar k = 0; k < NumCh; k++) begin : g_chan
    dmux_chan_fifo #(
      .Width (WIDTH),
      .Depth (DEPTH)
    ) u_chan (
      .clk_i     (CLK),
      .rst_ni    (RESET_N),
      .push_i    (push_en[k]),
      .data_i    (IN_DATA),
      .ready_i   (ready_v[k]),
      .cnt_clr_i (CNT_CLR),
      .full_o    (full[k]),
      .valid_o   (valid_v[k]),
      .data_o    (out_v[k]),
      .cnt_o     (cnt_v[k])
    );
  end

  assign OUT_A   = out_v[CH_A];
  assign OUT_B   = out_v[CH_B];
  assign OUT_C   = out_v[CH_C];
  assign OUT_D   = out_v[CH_D];
  assign VALID_A = valid_v[CH_A];
  assign VALID_B = valid_v[CH_B];
  assign VALID_C = valid_v[CH_C];
  assign VALID_D = valid_v[CH_D];
  assign CNT_A   = cnt_v[CH_A];
  assign CNT_B   = cnt_v[CH_B];
  assign CNT_C   = cnt_v[CH_C];
  assign CNT_D   = cnt_v[CH_D];

endmodule

// File: tb/tb_dmux4way16_stream.sv
// Scoreboard bench for dmux4way16_stream: the driver queues expected words per channel
// on acceptance, a monitor pops and compares on every delivered word.
module tb_dmux4way16_stream;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  logic [15:0] IN_DATA = '0;
  logic [1:0]  IN_SEL = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] out_a, out_b, out_c, out_d;
  logic        VALID_A, VALID_B, VALID_C, VALID_D;
  logic [3:0]  ready = 4'hF;
  logic [15:0] cnt_a, cnt_b, cnt_c, cnt_d;
  logic        clr = 1'b0;

  logic [3:0]  rdy_next = 4'hF;
  logic        clr_next = 1'b0;
  logic [3:0]  valid_v;

  int checks = 0;
  int errors = 0;

  logic [15:0] q_a[$], q_b[$], q_c[$], q_d[$];

  localparam logic [15:0] ROUTE [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

  assign valid_v = {VALID_D, VALID_C, VALID_B, VALID_A};

  dmux4way16_stream dut (
    .CLK      (CLK),
    .RESET_N  (RESET_N),
    .IN_DATA  (IN_DATA),
    .IN_SEL   (IN_SEL),
    .IN_VALID (IN_VALID),
    .IN_READY (IN_READY),
    .OUT_A    (out_a),
    .OUT_B    (out_b),
    .OUT_C    (out_c),
    .OUT_D    (out_d),
    .VALID_A  (VALID_A),
    .VALID_B  (VALID_B),
    .VALID_C  (VALID_C),
    .VALID_D  (VALID_D),
    .READY_A  (ready[0]),
    .READY_B  (ready[1]),
    .READY_C  (ready[2]),
    .READY_D  (ready[3]),
    .CNT_A    (cnt_a),
    .CNT_B    (cnt_b),
    .CNT_C    (cnt_c),
    .CNT_D    (cnt_d),
    .CNT_CLR  (clr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] out_of(input int k);
    case (k)
      0:       return out_a;
      1:       return out_b;
      2:       return out_c;
      default: return out_d;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q_a.size();
      1:       return q_b.size();
      2:       return q_c.size();
      default: return q_d.size();
    endcase
  endfunction

  function automatic logic [15:0] qpop(input int k);
    case (k)
      0:       return q_a.pop_front();
      1:       return q_b.pop_front();
      2:       return q_c.pop_front();
      default: return q_d.pop_front();
    endcase
  endfunction

  function automatic void qpush(input logic [1:0] k, input logic [15:0] d);
    case (k)
      2'd0:    q_a.push_back(d);
      2'd1:    q_b.push_back(d);
      2'd2:    q_c.push_back(d);
      default: q_d.push_back(d);
    endcase
  endfunction

  // Monitor: samples just before each rising edge, when all inputs are settled.
  logic [15:0] prev_out [4];
  logic [3:0]  prev_valid = '0;
  logic [3:0]  prev_ready = '0;
  logic        prev_rst = 1'b0;

  always @(negedge CLK) begin
    #4;
    if (RESET_N && prev_rst) begin
      for (int k = 0; k < 4; k++) begin
        if (prev_valid[k] && !prev_ready[k]) begin
          check($sformatf("ch%0d valid held", k), {31'b0, valid_v[k]}, 32'd1);
          check($sformatf("ch%0d out held", k), {16'b0, out_of(k)}, {16'b0, prev_out[k]});
        end
        if (valid_v[k] && ready[k]) begin
          if (qsize(k) == 0) begin
            checks++;
            errors++;
            $display("FAIL ch%0d unexpected word: got %h required none", k, out_of(k));
          end else begin
            check($sformatf("ch%0d data", k), {16'b0, out_of(k)}, {16'b0, qpop(k)});
          end
        end
      end
    end
    for (int k = 0; k < 4; k++) prev_out[k] = out_of(k);
    prev_valid = valid_v;
    prev_ready = ready;
    prev_rst   = RESET_N;
  end

  // One cycle of stimulus; acceptance is judged after the inputs settle.
  task automatic drive(input logic [15:0] d, input logic [1:0] s, input logic v,
                       output logic acc);
    @(negedge CLK);
    IN_DATA  = d;
    IN_SEL   = s;
    IN_VALID = v;
    ready    = rdy_next;
    clr      = clr_next;
    #1;
    acc = v && IN_READY;
    if (acc) qpush(s, d);
  endtask

  task automatic idle();
    logic acc;
    drive(16'h0, 2'd0, 1'b0, acc);
  endtask

  task automatic drain();
    int left;
    for (int i = 0; i < 50; i++) begin
      left = q_a.size() + q_b.size() + q_c.size() + q_d.size();
      if (left == 0) break;
      idle();
    end
    left = q_a.size() + q_b.size() + q_c.size() + q_d.size();
    check("drain words left", left, 0);
  endtask

  initial begin
    logic acc;
    int   nacc;

    // Reset / idle
    #2 RESET_N = 1'b0;
    repeat (2) @(negedge CLK);
    #1;
    check("reset in_ready", {31'b0, IN_READY}, 32'd0);
    check("reset valid", {28'b0, valid_v}, 32'd0);
    for (int k = 0; k < 4; k++) check($sformatf("reset out%0d", k), {16'b0, out_of(k)}, 0);
    check("reset cnt", {cnt_a, cnt_b} | {cnt_c, cnt_d}, 32'd0);
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int s = 0; s < 4; s++) begin
      IN_SEL = 2'(s);
      #1;
      check($sformatf("idle in_ready sel%0d", s), {31'b0, IN_READY}, 32'd1);
    end

    // Routing, back-to-back, one cycle latency
    for (int k = 0; k < 4; k++) begin
      drive(ROUTE[k], 2'(k), 1'b1, acc);
      check($sformatf("route accept %0d", k), {31'b0, acc}, 32'd1);
      if (k > 0) check($sformatf("route valid after %0d", k - 1), {28'b0, valid_v},
                       32'(4'b0001 << (k - 1)));
    end
    idle();
    check("route valid after 3", {28'b0, valid_v}, 32'h8);
    idle();
    check("route valid idle", {28'b0, valid_v}, 32'h0);
    check("route cnt a", {16'b0, cnt_a}, 32'd1);
    check("route cnt b", {16'b0, cnt_b}, 32'd1);
    check("route cnt c", {16'b0, cnt_c}, 32'd1);
    check("route cnt d", {16'b0, cnt_d}, 32'd1);

    // Backpressure / full on B, C still flows
    rdy_next = 4'b1101;
    drive(16'hA001, 2'd1, 1'b1, acc);
    check("bp accept a001", {31'b0, acc}, 32'd1);
    drive(16'hA002, 2'd1, 1'b1, acc);
    check("bp accept a002", {31'b0, acc}, 32'd1);
    drive(16'hA003, 2'd1, 1'b1, acc);
    check("bp refuse a003", {31'b0, acc}, 32'd0);
    drive(16'h5555, 2'd2, 1'b1, acc);
    check("bp accept c while b full", {31'b0, acc}, 32'd1);
    rdy_next = 4'hF;
    drive(16'hA003, 2'd1, 1'b1, acc);
    check("bp refuse while popping", {31'b0, acc}, 32'd0);
    drive(16'hA003, 2'd1, 1'b1, acc);
    check("bp accept a003", {31'b0, acc}, 32'd1);
    drain();
    check("bp cnt b", {16'b0, cnt_b}, 32'd4);

    // Simultaneous push/pop on D
    rdy_next = 4'b0111;
    drive(16'hD000, 2'd3, 1'b1, acc);
    check("d preload accept", {31'b0, acc}, 32'd1);
    rdy_next = 4'hF;
    for (int i = 0; i < 8; i++) begin
      drive((i == 0) ? 16'hBEEF : 16'hD000 + 16'(i + 1), 2'd3, 1'b1, acc);
      check($sformatf("stream accept %0d", i), {31'b0, acc}, 32'd1);
      check($sformatf("stream valid %0d", i), {31'b0, VALID_D}, 32'd1);
    end
    drain();

    // CNT_CLR leaves FIFO contents alone; clear beats a same-cycle pop
    rdy_next = 4'b1011;
    drive(16'h6666, 2'd2, 1'b1, acc);
    clr_next = 1'b1;
    idle();
    clr_next = 1'b0;
    idle();
    check("clr cnt a", {16'b0, cnt_a}, 32'd0);
    check("clr cnt b", {16'b0, cnt_b}, 32'd0);
    check("clr cnt d", {16'b0, cnt_d}, 32'd0);
    check("clr keeps c valid", {31'b0, VALID_C}, 32'd1);
    check("clr keeps c data", {16'b0, out_c}, 32'h6666);
    rdy_next = 4'hF;
    clr_next = 1'b1;
    idle();
    clr_next = 1'b0;
    idle();
    check("clr wins over pop", {16'b0, cnt_c}, 32'd0);
    check("c empty after pop", {31'b0, VALID_C}, 32'd0);

    // Counter wrap on A
    nacc = 0;
    for (int i = 0; i < 65535; i++) begin
      drive(16'(i), 2'd0, 1'b1, acc);
      if (acc) nacc++;
    end
    check("wrap accepts", nacc, 65535);
    idle();
    idle();
    check("cnt a ffff", {16'b0, cnt_a}, 32'hFFFF);
    drive(16'hAAAA, 2'd0, 1'b1, acc);
    idle();
    idle();
    check("cnt a wraps", {16'b0, cnt_a}, 32'd0);

    // Invalid input ignored
    drive(16'hB001, 2'd1, 1'b1, acc);
    drive(16'hB002, 2'd1, 1'b1, acc);
    drain();
    for (int s = 0; s < 4; s++) begin
      drive(16'hDEAD, 2'(s), 1'b0, acc);
      check($sformatf("invalid valid sel%0d", s), {28'b0, valid_v}, 32'd0);
    end
    idle();
    check("invalid valid end", {28'b0, valid_v}, 32'd0);
    check("invalid cnt a", {16'b0, cnt_a}, 32'd0);
    check("invalid cnt b", {16'b0, cnt_b}, 32'd2);
    check("invalid cnt c", {16'b0, cnt_c}, 32'd0);
    check("invalid cnt d", {16'b0, cnt_d}, 32'd0);

    // Asynchronous reset mid-cycle discards buffered words
    rdy_next = 4'b1101;
    drive(16'h7777, 2'd1, 1'b1, acc);
    drive(16'h8888, 2'd1, 1'b1, acc);
    idle();
    check("pre-reset b valid", {31'b0, VALID_B}, 32'd1);
    @(posedge CLK);
    #2;
    RESET_N = 1'b0;
    q_b.delete();
    #1;
    check("async reset b valid", {31'b0, VALID_B}, 32'd0);
    check("async reset b out", {16'b0, out_b}, 32'd0);
    check("async reset cnt b", {16'b0, cnt_b}, 32'd0);
    check("async reset in_ready", {31'b0, IN_READY}, 32'd0);
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;
    rdy_next = 4'hF;
    idle();
    check("post-reset in_ready b", {31'b0, IN_READY}, 32'd1);
    drive(16'h9999, 2'd1, 1'b1, acc);
    check("post-reset accept", {31'b0, acc}, 32'd1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
